// File: rtl/sample_pacer.sv
`timescale 1ns/1ps
// sample_pacer
//   Buffers raw samples from an upstream source in a small FIFO and releases
//   them at a fixed cadence (one every PERIOD clocks) toward a filter. Each
//   released sample gets a signed DC offset added, with saturation to 16 bits.
//
// Ports
//   clk_in            sole clock, rising edge
//   rst_in            asynchronous reset, active low
//   sample_valid_in   upstream offers sample_in this cycle
//   sample_in         signed raw sample
//   sample_ready_out  FIFO has room (registered occupancy < DEPTH)
//   ready_out         one-cycle strobe: x_out holds a new sample
//   x_out             offset-corrected, saturated sample; held between strobes
//   warm_out          sticky: WARMUP strobes have been issued
//   sample_count_out  strobes issued since reset, wraps modulo 2^21
//   underrun_out      sticky: a strobe slot found the FIFO empty
//   fill_out          current FIFO occupancy
module sample_pacer #(
  parameter int PERIOD = 128,
  parameter int OFFSET = 1780,
  parameter int DEPTH  = 16,
  parameter int WARMUP = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          sample_valid_in,
  input  logic [15:0]   sample_in,
  output logic          sample_ready_out,
  output logic          ready_out,
  output logic [15:0]   x_out,
  output logic          warm_out,
  output logic [20:0]   sample_count_out,
  output logic          underrun_out,
  output logic [AW:0]   fill_out
);

  localparam logic signed [16:0] OFF17 = 17'(OFFSET);

  logic [PW-1:0] phase_q, phase_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          ready_q, ready_d;
  logic [15:0]   x_q, x_d;
  logic [20:0]   cnt_q, cnt_d;
  logic          warm_q, warm_d;
  logic          under_q, under_d;

  logic [15:0]   mem [DEPTH];

  logic          tick;
  logic          push;
  logic          pop;
  logic [16:0]   sum;
  logic [15:0]   sat_val;

  // Room is judged on registered occupancy only, so a full FIFO stays
  // closed on a popping cycle and the freed slot opens one cycle later.
  assign sample_ready_out = (fill_q < (AW+1)'(DEPTH));
  assign tick             = (phase_q == PW'(PERIOD - 1));
  assign push             = sample_valid_in & sample_ready_out;
  // Emptiness also comes from registered occupancy: a sample pushed on the
  // tick cycle itself is not visible to that tick.
  assign pop              = tick & (fill_q != '0);

  // 17-bit sum cannot overflow for 16-bit operands; bits [16:15] disagreeing
  // means the true result lies outside the 16-bit signed range.
  always_comb begin
    sum     = {mem[rd_ptr_q][15], mem[rd_ptr_q]} + OFF17;
    sat_val = sum[15:0];
    if (!sum[16] && sum[15])      sat_val = 16'h7FFF;
    else if (sum[16] && !sum[15]) sat_val = 16'h8000;
  end

  always_comb begin
    phase_d  = tick ? '0 : phase_q + 1'b1;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
    ready_d  = pop;
    x_d      = pop ? sat_val : x_q;
    cnt_d    = pop ? cnt_q + 1'b1 : cnt_q;
    warm_d   = warm_q | (pop && (cnt_d == 21'(WARMUP)));
    under_d  = under_q | (tick && (fill_q == '0));
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      phase_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ready_q  <= 1'b0;
      x_q      <= '0;
      cnt_q    <= '0;
      warm_q   <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ready_q  <= ready_d;
      x_q      <= x_d;
      cnt_q    <= cnt_d;
      warm_q   <= warm_d;
      under_q  <= under_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is live.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr_q] <= sample_in;
  end

  assign ready_out        = ready_q;
  assign x_out            = x_q;
  assign warm_out         = warm_q;
  assign sample_count_out = cnt_q;
  assign underrun_out     = under_q;
  assign fill_out         = fill_q;

endmodule

// File: tb/tb_sample_pacer.sv
`timescale 1ns/1ps
module tb_sample_pacer;
  localparam int PERIOD = 128;
  localparam int OFFSET = 1780;
  localparam int DEPTH  = 16;
  localparam int WARMUP = 64;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        sample_valid_in = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_ready_out;
  logic        ready_out;
  logic [15:0] x_out;
  logic        warm_out;
  logic [20:0] sample_count_out;
  logic        underrun_out;
  logic [4:0]  fill_out;

  sample_pacer #(.PERIOD(PERIOD), .OFFSET(OFFSET), .DEPTH(DEPTH), .WARMUP(WARMUP)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .sample_valid_in(sample_valid_in), .sample_in(sample_in),
    .sample_ready_out(sample_ready_out), .ready_out(ready_out), .x_out(x_out),
    .warm_out(warm_out), .sample_count_out(sample_count_out),
    .underrun_out(underrun_out), .fill_out(fill_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (t=%0t)", n, act, exp, $time);
    end
  endtask

  function automatic int sat16(input int s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  // Behavioural model: edges since release; every PERIOD-th edge is a strobe
  // slot. The slot sees the queue as it stood before this edge's push.
  int q[$];
  int m_x, m_cnt, ecnt, m_fb;
  bit m_ready, m_warm, m_under, cmp_en = 1'b0;

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      q.delete();
      m_x = 0; m_cnt = 0; ecnt = 0;
      m_ready = 0; m_warm = 0; m_under = 0;
    end else begin
      ecnt++;
      m_fb = q.size();
      m_ready = 0;
      if (ecnt % PERIOD == 0) begin
        if (m_fb > 0) begin
          m_x = sat16(q.pop_front() + OFFSET);
          m_ready = 1;
          m_cnt = (m_cnt + 1) % (1 << 21);
          if (m_cnt == WARMUP) m_warm = 1;
        end else m_under = 1;
      end
      if (sample_valid_in && m_fb < DEPTH) q.push_back(int'($signed(sample_in)));
    end
  end

  always @(negedge clk_in) begin
    if (cmp_en && rst_in) begin
      chk("ready_out", int'(ready_out), int'(m_ready));
      chk("x_out", int'($signed(x_out)), m_x);
      chk("sample_count_out", int'(sample_count_out), m_cnt);
      chk("warm_out", int'(warm_out), int'(m_warm));
      chk("underrun_out", int'(underrun_out), int'(m_under));
      chk("fill_out", int'(fill_out), q.size());
      chk("sample_ready_out", int'(sample_ready_out), int'(q.size() < DEPTH));
    end
  end

  task automatic push(input int v);
    sample_valid_in = 1'b1;
    sample_in = 16'(v);
    @(posedge clk_in); #1;
    sample_valid_in = 1'b0;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_ready"}, int'(ready_out), 0);
    chk({tag, "_x"}, int'(x_out), 0);
    chk({tag, "_count"}, int'(sample_count_out), 0);
    chk({tag, "_warm"}, int'(warm_out), 0);
    chk({tag, "_under"}, int'(underrun_out), 0);
    chk({tag, "_fill"}, int'(fill_out), 0);
    chk({tag, "_sready"}, int'(sample_ready_out), 1);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    sample_valid_in = 1'b0;
    #2;
    reset_vals("rst");
    @(negedge clk_in);
    rst_in = 1'b1;
    cmp_en = 1'b1;
  endtask

  task automatic wait_ready(output int x, output int c, output int e);
    bit found = 0;
    x = 0; c = 0; e = 0;
    for (int i = 0; i < 3 * PERIOD && !found; i++) begin
      @(negedge clk_in);
      if (ready_out) begin
        found = 1;
        x = int'($signed(x_out));
        c = int'(sample_count_out);
        e = ecnt;
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual none expected pulse within %0d clocks", 3 * PERIOD);
    end
  endtask

  int rx, rc, re;
  int exp_x[5] = '{1783, 1775, 1880, 32767, -30988};

  initial begin
    // Basic pacing, offset and first-strobe latency.
    do_reset();
    push(3); push(-5); push(100);
    for (int i = 0; i < 3; i++) begin
      wait_ready(rx, rc, re);
      chk("basic_x", rx, exp_x[i]);
      chk("basic_count", rc, i + 1);
      chk("basic_edge", re, PERIOD * (i + 1));
      chk("basic_under", int'(underrun_out), 0);
    end
    // Saturation.
    push(31000); push(-32768);
    for (int i = 3; i < 5; i++) begin
      wait_ready(rx, rc, re);
      chk("sat_x", rx, exp_x[i]);
      chk("sat_count", rc, i + 1);
    end

    // Overfill: 17 back-to-back, only 16 stored, FIFO order kept.
    do_reset();
    sample_valid_in = 1'b1;
    for (int i = 0; i < 17; i++) begin
      sample_in = 16'(i * 1000 - 8000);
      @(posedge clk_in); #1;
    end
    sample_valid_in = 1'b0;
    @(negedge clk_in);
    chk("full_fill", int'(fill_out), 16);
    chk("full_sready", int'(sample_ready_out), 0);
    for (int i = 0; i < 16; i++) begin
      wait_ready(rx, rc, re);
      chk("order_x", rx, i * 1000 - 8000 + OFFSET);
    end

    // Idle through first tick, then push onto the next... tick cycle itself.
    do_reset();
    repeat (PERIOD - 1) @(negedge clk_in);
    chk("pre_tick_under", int'(underrun_out), 0);
    sample_valid_in = 1'b1;
    sample_in = 16'(500);
    @(posedge clk_in); #1;
    sample_valid_in = 1'b0;
    @(negedge clk_in);
    chk("tick_under", int'(underrun_out), 1);
    chk("tick_ready", int'(ready_out), 0);
    wait_ready(rx, rc, re);
    chk("late_x", rx, 2280);
    chk("late_edge", re, 2 * PERIOD);
    chk("late_count", rc, 1);

    // Warm-up: FIFO kept fed for 64 slots, random values.
    do_reset();
    for (int c = 0; c < WARMUP * PERIOD - 1; c++) begin
      sample_valid_in = (c % 32 == 0) || ($urandom_range(0, 99) < 4);
      sample_in = 16'($urandom);
      @(posedge clk_in); #1;
    end
    sample_valid_in = 1'b0;
    @(negedge clk_in);
    chk("prewarm_warm", int'(warm_out), 0);
    chk("prewarm_count", int'(sample_count_out), WARMUP - 1);
    @(negedge clk_in);
    chk("warm_warm", int'(warm_out), 1);
    chk("warm_count", int'(sample_count_out), WARMUP);
    chk("warm_under", int'(underrun_out), 0);

    // Asynchronous reset mid-period, no clock edge needed.
    repeat (40) @(posedge clk_in);
    #3;
    rst_in = 1'b0;
    #1;
    reset_vals("async");
    @(negedge clk_in);
    rst_in = 1'b1;

    // Random traffic: sparse (underruns), dense (full + pop), sparse again.
    for (int seg = 0; seg < 3; seg++) begin
      for (int c = 0; c < 1000; c++) begin
        sample_valid_in = ($urandom_range(0, 99) < ((seg == 1) ? 90 : 1));
        sample_in = 16'($urandom);
        @(posedge clk_in); #1;
      end
    end
    sample_valid_in = 1'b0;
    @(negedge clk_in);
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_pacer.md
SAMPLE_PACER -- requirements
Module: sample_pacer

Interface
REQ-001 Parameter PERIOD, default 128: clocks between consecutive output sample strobes.
REQ-002 Parameter OFFSET, default 1780: signed DC offset added to every sample before output.
REQ-003 Parameter DEPTH, default 16 (power of two): input FIFO depth in samples.
REQ-004 Parameter WARMUP, default 64: number of strobes issued before warm_out rises.
REQ-005 clk_in  input  1  sole clock; all logic on rising edge.
REQ-006 rst_in  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 sample_valid_in  input  1  upstream offers sample_in this cycle.
REQ-008 sample_in  input  16  signed two's-complement raw sample.
REQ-009 sample_ready_out  output  1  FIFO can accept; high when FIFO occupancy < DEPTH.
REQ-010 ready_out  output  1  one-cycle strobe to the filter: x_out holds a new sample.
REQ-011 x_out  output  16  signed offset-corrected sample, stable between strobes.
REQ-012 warm_out  output  1  high once WARMUP strobes have been issued; filter output valid from then on.
REQ-013 sample_count_out  output  21  number of strobes issued since reset, wraps modulo 2^21.
REQ-014 underrun_out  output  1  sticky: a strobe slot found the FIFO empty.
REQ-015 fill_out  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Free-running phase counter counts 0..PERIOD-1, then wraps to 0; it does not depend on FIFO state.
REQ-017 Push: sample accepted into FIFO on a cycle where sample_valid_in=1 and sample_ready_out=1; otherwise sample_in is ignored and not stored.
REQ-018 Tick: the cycle where phase counter = PERIOD-1.
REQ-019 On a tick with FIFO non-empty: pop the oldest sample; the next cycle has ready_out=1 and x_out = that sample + OFFSET (saturated); sample_count_out increments on that same next cycle.
REQ-020 ready_out is high for exactly one clock per successful tick and low on all other cycles.
REQ-021 On a tick with FIFO empty: no pop; ready_out stays 0; x_out and sample_count_out hold; underrun_out set to 1 the next cycle and held until reset.
REQ-022 Arithmetic: sum formed at 17 bits signed; results > 32767 clamp to 32767 and results < -32768 clamp to -32768.
REQ-023 FIFO order is strictly first-in first-out; pointers wrap modulo DEPTH.
REQ-024 Push and pop in the same cycle: both take effect and occupancy is unchanged.
REQ-025 Push and tick in the same cycle with the FIFO empty: the tick sees an empty FIFO (underrun); the pushed sample is popped no earlier than the next tick.
REQ-026 When the FIFO is full, sample_ready_out=0 even if a pop occurs that cycle; the freed slot is offered on the following cycle.
REQ-027 sample_ready_out and fill_out are derived from registered occupancy only; there is no combinational path from sample_valid_in.
REQ-028 warm_out rises on the cycle sample_count_out first reaches WARMUP and stays high until reset, including across wrap of sample_count_out.

Reset
REQ-029 While rst_in=0, asynchronously and immediately: phase counter=0, FIFO empty, fill_out=0, sample_ready_out=1 (combinational from empty), ready_out=0, x_out=0, sample_count_out=0, warm_out=0, underrun_out=0.
REQ-030 Reset asserted mid-operation discards all FIFO contents.
REQ-031 The first tick after release occurs PERIOD-1 clocks after the first rising edge with rst_in=1.

Verification
REQ-032 Push 3, -5, 100 right after reset, then idle -> three ready_out pulses 128 clocks apart with x_out = 1783, 1775, 1880; sample_count_out = 1, 2, 3; underrun_out = 0.
REQ-033 Push 31000 and -32768 -> x_out = 32767 (clamped), then -30988.
REQ-034 Push 17 samples back-to-back with sample_valid_in held high -> 16 accepted, sample_ready_out=0, fill_out=16, 17th not stored; outputs follow order of the first 16.
REQ-035 No pushes through the first tick -> ready_out never pulses, underrun_out=1 from the cycle after the tick; a later push is emitted on the following tick.
REQ-036 Keep the FIFO non-empty for 64 ticks -> warm_out rises with sample_count_out=64; assert rst_in=0 mid-period -> all outputs return to reset values without waiting for a clock edge.
REQ-037 Single push timed onto the tick cycle with the FIFO empty -> underrun on that tick; the sample is emitted exactly PERIOD clocks later.
